stream_rejoin: RTL and testbench
================================

// Module: stream_rejoin
// PURPOSE
//  Receiving-end counterpart of a tap: rejoins a side stream that carries SIDE_REP
//   beats per primary item with the primary stream itself.
//  Consumes one primary beat per output beat, plus exactly SIDE_REP side beats.
//  The side beats are reduced by wrapping unsigned summation.
//  Emits the primary data paired with the reduced side value.
//  Sits downstream of workers fed by replicated tap copies; restores 1:1 item alignment.
// PARAMETERS
//  DATA_WIDTH  9   width of primary data (idat/odat)
//  SIDE_WIDTH  9   width of one side beat (sdat)
//  ACC_WIDTH   16  width of reduced side value (oacc); sum wraps mod 2**ACC_WIDTH
//  SIDE_REP    7   side beats per primary item; legal range >=1
// PORTS
//  clk   in   1           clock, all state on rising edge
//  rst   in   1           synchronous, active-high reset
//  idat  in   DATA_WIDTH  primary data
//  ivld  in   1           primary valid
//  irdy  out  1           primary ready
//  sdat  in   SIDE_WIDTH  side data
//  svld  in   1           side valid
//  srdy  out  1           side ready
//  odat  out  DATA_WIDTH  joined primary data
//  oacc  out  ACC_WIDTH   sum of the SIDE_REP side beats of this item
//  ovld  out  1           output valid
//  ordy  in   1           output ready
// BEHAVIOUR
//  Handshakes: valid/ready; a transfer occurs on a rising edge with vld&&rdy.
//   Valid, once raised, is never dropped before its transfer.
//  State: cnt in [0,SIDE_REP-1]; acc (ACC_WIDTH); done flag (group complete).
//  Reset values: cnt=0, acc=0, done=0.
//   ovld=0, irdy=0, srdy=0 while rst is high; srdy=1 in the first cycle after reset.
//  Side accumulation (done=0, srdy=1):
//   each side transfer does acc<=acc+zext(sdat) mod 2**ACC_WIDTH and cnt<=cnt+1.
//   On the SIDE_REP-th transfer: cnt<=0, done<=1.
//  Join (done=1):
//   ovld = ivld; irdy = ordy; odat = idat; oacc = acc.
//   No primary beat is ever consumed without a complete side group.
//  Join fire (ivld&&ordy&&done): done<=0, acc<=0.
//  srdy = !done || join_fire.
//   A side beat in the join-fire cycle starts the next group: acc<=zext(sdat), cnt<=1.
//   If SIDE_REP==1, done stays 1 instead.
//  Throughput:
//   one output per max(SIDE_REP, primary/output rate) cycles.
//   SIDE_REP==1 sustains 1 item/cycle with all streams valid/ready.
//  Latency: a completed group is visible at the output the cycle after its last side transfer.
//  Primary arriving before its group completes: held (irdy=0) with no timeout.
//  Side data of later groups: stalled (srdy=0) while done=1 and no join fire.
//  Reset mid-group: partial acc/cnt discarded; the next side beat is the first of a new group.
// CONFIGURATION
//  STREAM_REJOIN_OREG_EN defined:
//   adds a full-throughput valid/ready output register after the join.
//   Join fire becomes ivld && done && (!ovld_q || ordy).
//   +1 cycle latency; ovld_q resets to 0; odat/oacc are registered.
//  Undefined: output is combinational from idat/acc as above.
//  Transfer order and values are identical either way.
// STRUCTURE
//  Shared package stream_pkg:
//   function clog2p1 for the cnt width (width $clog2(SIDE_REP)+1 for SIDE_REP==1 safety).
//   Typedef templates for the acc/data types, parameterized via module localparams.
//  Sub-module stream_rejoin_acc holds cnt/acc/done.
//   Ports: clk, rst, sdat, svld, srdy, take (=join fire), acc, done.
//  Top: join logic plus the optional output register (inline, `ifdef STREAM_REJOIN_OREG_EN).
// TESTING (SIDE_REP=7, DATA_WIDTH=SIDE_WIDTH=9, ACC_WIDTH=16 unless noted)
//  1. Basic: idat=0, side beats 1..7, ordy=1.
//     -> one output odat=0, oacc=28; no second output.
//  2. Wrap: ACC_WIDTH=8, side beats 255 x7.
//     -> oacc=249 (1785 mod 256).
//  3. Early primary: idat=5 held valid from cycle 0, side beats trickle in one per 3 cycles.
//     -> irdy=0 and ovld=0 until the cycle after the 7th side beat, then odat=5.
//  4. Backpressure: ordy=0 for 20 cycles with group done.
//     -> srdy=0, ovld=1 and stable odat/oacc throughout.
//     -> On ordy=1 the output fires; a side beat in that same cycle is accepted as beat 1 of the next group.
//  5. Reset mid-group: 3 side beats (10,20,30), rst for 1 cycle, then 7 beats of 1 with idat=9.
//     -> oacc=7, odat=9.
//  6. Random: 1357 rounds, idat=r, side beats r x7, random stalls on all ports, both macro settings.
//     -> odat==r and oacc==7*r mod 2**16, in order.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared helpers for the stream join/tap blocks.
// Provides the counter-width function and default widths.
package stream_pkg;

    localparam int DEF_DATA_WIDTH = 9;
    localparam int DEF_SIDE_WIDTH = 9;
    localparam int DEF_ACC_WIDTH  = 16;

    // One bit wider than $clog2 so a repeat count of 1 still gets a real counter.
    function automatic int clog2p1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/stream_rejoin_acc.sv
// Side-stream group accumulator: sums SIDE_REP side beats and flags the group complete.
// A take in the same cycle as a side beat starts the next group with that beat.
module stream_rejoin_acc
    import stream_pkg::*;
#(
    parameter int SIDE_WIDTH = DEF_SIDE_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SIDE_REP   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIDE_WIDTH-1:0] sdat,
    input  logic                  svld,
    output logic                  srdy,
    input  logic                  take,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  done
);

    localparam int CNT_WIDTH = clog2p1(SIDE_REP);

    typedef logic [ACC_WIDTH-1:0] acc_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(SIDE_REP - 1);

    cnt_t cnt;
    acc_t acc_base;
    logic side_fire;

    assign srdy      = !rst && (!done || take);
    assign side_fire = svld && srdy;
    assign acc_base  = take ? '0 : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            acc  <= '0;
            done <= 1'b0;
        end else begin
            if (take) begin
                done <= 1'b0;
                acc  <= '0;
            end
            // Later assignments win: a side beat during take begins the next group.
            if (side_fire) begin
                acc <= acc_base + acc_t'(sdat);
                if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + cnt_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/stream_rejoin.sv
// Rejoins a SIDE_REP-beat side stream with its primary stream, emitting data plus summed side value.
// Optional output register enabled by defining STREAM_REJOIN_OREG_EN.
module stream_rejoin
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIDE_WIDTH = DEF_SIDE_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int SIDE_REP   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] idat,
    input  logic                  ivld,
    output logic                  irdy,
    input  logic [SIDE_WIDTH-1:0] sdat,
    input  logic                  svld,
    output logic                  srdy,
    output logic [DATA_WIDTH-1:0] odat,
    output logic [ACC_WIDTH-1:0]  oacc,
    output logic                  ovld,
    input  logic                  ordy
);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ACC_WIDTH-1:0]  acc_t;

    logic take;
    logic done;
    acc_t acc;

    stream_rejoin_acc #(
        .SIDE_WIDTH(SIDE_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIDE_REP  (SIDE_REP)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .sdat(sdat),
        .svld(svld),
        .srdy(srdy),
        .take(take),
        .acc (acc),
        .done(done)
    );

`ifdef STREAM_REJOIN_OREG_EN
    logic  ovld_q;
    data_t odat_q;
    acc_t  oacc_q;
    logic  slot_free;

    // Register can accept a new item whenever it is empty or draining this cycle.
    assign slot_free = !ovld_q || ordy;
    assign take      = !rst && ivld && done && slot_free;
    assign irdy      = !rst && done && slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovld_q <= 1'b0;
        end else if (take) begin
            ovld_q <= 1'b1;
        end else if (ordy) begin
            ovld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            odat_q <= idat;
            oacc_q <= acc;
        end
    end

    assign ovld = ovld_q && !rst;
    assign odat = odat_q;
    assign oacc = oacc_q;
`else
    assign take = !rst && ivld && done && ordy;
    assign irdy = !rst && done && ordy;
    assign ovld = !rst && done && ivld;
    assign odat = idat;
    assign oacc = acc;
`endif

endmodule

// File: tb/tb_stream_rejoin.sv
// Randomized self-checking bench for stream_rejoin, with a queue-based group/item scoreboard.
// A second instance with ACC_WIDTH=8 shares the stimulus to exercise sum wrap-around.
module tb_stream_rejoin;

`ifdef STREAM_REJOIN_OREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int REP = 7;

    typedef struct {
        int d;
        int s;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] idat, sdat;
    logic       ivld, svld, ordy;
    logic       irdy, srdy, ovld;
    logic [8:0] odat;
    logic [15:0] oacc;
    logic       irdy8, srdy8, ovld8;
    logic [8:0] odat8;
    logic [7:0] oacc8;

    stream_rejoin #(.DATA_WIDTH(9), .SIDE_WIDTH(9), .ACC_WIDTH(16), .SIDE_REP(REP)) dut (
        .clk(clk), .rst(rst), .idat(idat), .ivld(ivld), .irdy(irdy),
        .sdat(sdat), .svld(svld), .srdy(srdy),
        .odat(odat), .oacc(oacc), .ovld(ovld), .ordy(ordy)
    );

    stream_rejoin #(.DATA_WIDTH(9), .SIDE_WIDTH(9), .ACC_WIDTH(8), .SIDE_REP(REP)) dut8 (
        .clk(clk), .rst(rst), .idat(idat), .ivld(ivld), .irdy(irdy8),
        .sdat(sdat), .svld(svld), .srdy(srdy8),
        .odat(odat8), .oacc(oacc8), .ovld(ovld8), .ordy(ordy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // stimulus queues and knobs
    int side_q[$];
    int prim_q[$];
    int s_stall = 0, p_stall = 0, o_stall = 0, s_gap = 0;
    int s_idle = 0;
    bit s_fire_n = 0, p_fire_n = 0;

    // reference model state
    int    part_n = 0, part_sum = 0;
    int    grp_q[$];
    item_t exp_q[$];
    int    cyc = 0, cyc_side = 0, cyc_prim = 0, cyc_out = 0, ovld_first = 0;
    int    side_cnt = 0, out_cnt = 0;
    int    last_odat = 0, last_oacc = 0, last_oacc8 = 0;
    bit    have_prev = 0, prev_ovld = 0, prev_ordy = 0;
    int    prev_odat = 0, prev_oacc = 0;

    // input drivers, updated just after each rising edge
    initial begin
        svld = 1'b0; ivld = 1'b0; ordy = 1'b0; sdat = '0; idat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_fire_n) begin
                svld   = 1'b0;
                s_idle = s_gap;
            end
            if (!svld) begin
                if (s_idle > 0) s_idle--;
                else if (side_q.size() > 0 && $urandom_range(99) >= s_stall) begin
                    sdat = 9'(side_q.pop_front());
                    svld = 1'b1;
                end
            end
            if (p_fire_n) ivld = 1'b0;
            if (!ivld && prim_q.size() > 0 && $urandom_range(99) >= p_stall) begin
                idat = 9'(prim_q.pop_front());
                ivld = 1'b1;
            end
            ordy = ($urandom_range(99) >= o_stall);
        end
    end

    // monitor and scoreboard, sampled at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            s_fire_n = 0;
            p_fire_n = 0;
            if (rst) begin
                chk("rst_ovld", 32'(ovld), 0);
                chk("rst_irdy", 32'(irdy), 0);
                chk("rst_srdy", 32'(srdy), 0);
                part_n = 0;
                part_sum = 0;
                grp_q.delete();
                exp_q.delete();
                have_prev = 0;
            end else begin
                if (have_prev && prev_ovld && !prev_ordy) begin
                    chk("hold_ovld", 32'(ovld), 1);
                    chk("hold_odat", 32'(odat), prev_odat);
                    chk("hold_oacc", 32'(oacc), prev_oacc);
                end
                if (ivld && irdy) begin
                    p_fire_n = 1;
                    cyc_prim = cyc;
                    chk("prim_has_group", 32'(grp_q.size() > 0), 1);
                    if (grp_q.size() > 0) exp_q.push_back('{d: int'(idat), s: grp_q.pop_front()});
                end
                if (svld && srdy) begin
                    s_fire_n = 1;
                    cyc_side = cyc;
                    side_cnt++;
                    part_sum += int'(sdat);
                    part_n++;
                    if (part_n == REP) begin
                        grp_q.push_back(part_sum);
                        part_n = 0;
                        part_sum = 0;
                    end
                end
                if (ovld && ovld_first == 0) ovld_first = cyc;
                if (ovld && ordy) begin
                    out_cnt++;
                    cyc_out = cyc;
                    last_odat = int'(odat);
                    last_oacc = int'(oacc);
                    last_oacc8 = int'(oacc8);
                    chk("dut8_hs", {19'd0, ovld8, irdy8, srdy8, odat8}, {19'd0, ovld, irdy, srdy, odat});
                    chk("exp_avail", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        item_t it;
                        it = exp_q.pop_front();
                        chk("odat", 32'(odat), it.d);
                        chk("oacc", 32'(oacc), it.s % 65536);
                        chk("oacc8", 32'(oacc8), it.s % 256);
                    end
                end
                have_prev = 1;
                prev_ovld = ovld;
                prev_ordy = ordy;
                prev_odat = int'(odat);
                prev_oacc = int'(oacc);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk("out_timeout", 32'(out_cnt >= target), 1);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("post_rst_srdy", 32'(srdy), 1);
        chk("post_rst_ovld", 32'(ovld), 0);
        chk("post_rst_irdy", 32'(irdy), 0);

        // basic group of 1..7
        prim_q.push_back(0);
        for (int i = 1; i <= REP; i++) side_q.push_back(i);
        wait_out(1, 100);
        chk("basic_odat", last_odat, 0);
        chk("basic_oacc", last_oacc, 28);
        repeat (20) step();
        chk("basic_single", out_cnt, 1);

        // wrap on the 8-bit instance
        prim_q.push_back(1);
        for (int i = 0; i < REP; i++) side_q.push_back(255);
        wait_out(2, 100);
        chk("wrap_oacc16", last_oacc, 1785);
        chk("wrap_oacc8", last_oacc8, 249);
        repeat (4) step();

        // early primary, side beats one per three cycles
        s_gap = 2;
        ovld_first = 0;
        prim_q.push_back(5);
        for (int i = 1; i <= REP; i++) side_q.push_back(i);
        wait_out(3, 200);
        chk("early_prim_cyc", cyc_prim, cyc_side + 1);
        chk("early_ovld_cyc", ovld_first, cyc_side + 1 + LAT);
        chk("early_odat", last_odat, 5);
        s_gap = 0;

        // backpressure with a next-group beat waiting
        o_stall = 100;
        repeat (3) step();
        base = out_cnt;
        prim_q.push_back(3);
        for (int i = 1; i <= REP; i++) side_q.push_back(i);
        side_q.push_back(100);
        for (int n = 0; n < 60 && !ovld; n++) step();
        chk("bp_ovld_up", 32'(ovld), 1);
        for (int i = 0; i < 20; i++) begin
            step();
`ifndef STREAM_REJOIN_OREG_EN
            chk("bp_srdy", 32'(srdy), 0);
`endif
            chk("bp_ovld", 32'(ovld), 1);
            chk("bp_odat", 32'(odat), 3);
            chk("bp_oacc", 32'(oacc), 28);
        end
        o_stall = 0;
        wait_out(base + 1, 50);
`ifndef STREAM_REJOIN_OREG_EN
        chk("bp_side_same_cyc", cyc_side, cyc_out);
`endif
        prim_q.push_back(4);
        for (int i = 1; i < REP; i++) side_q.push_back(i);
        wait_out(base + 2, 100);
        chk("bp_next_oacc", last_oacc, 121);

        // reset in the middle of a group
        base = side_cnt;
        side_q.push_back(10);
        side_q.push_back(20);
        side_q.push_back(30);
        for (int n = 0; n < 50 && side_cnt < base + 3; n++) step();
        chk("mid_side_cnt", side_cnt, base + 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("mid_rst_srdy", 32'(srdy), 1);
        base = out_cnt;
        prim_q.push_back(9);
        for (int i = 0; i < REP; i++) side_q.push_back(1);
        wait_out(base + 1, 100);
        chk("mid_odat", last_odat, 9);
        chk("mid_oacc", last_oacc, 7);

        // random rounds with stalls on every port
        s_stall = 30;
        p_stall = 30;
        o_stall = 30;
        base = out_cnt;
        for (int k = 0; k < 1357; k++) begin
            int r;
            r = int'($urandom_range(511));
            prim_q.push_back(r);
            for (int i = 0; i < REP; i++) side_q.push_back(r);
        end
        wait_out(base + 1357, 60000);
        repeat (5) step();
        chk("rand_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
